// File: rtl/rom_stream_reader_pkg.sv
// Shared types and constants for the ROM stream reader: FSM encoding and
// output FIFO depth.
package rom_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_stream_fifo.sv
// Two-entry output FIFO with a fall-through head: a word pushed into an empty
// FIFO is visible on dout in the same cycle and bypasses storage if popped.
module rom_stream_fifo
    import rom_stream_reader_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             empty;
    logic             store;
    logic             drain;

    assign empty = (count_q == 2'd0);
    // A push into an empty FIFO that is popped in the same cycle never lands.
    assign store = push & ~(pop & empty);
    assign drain = pop & ~empty;
    assign dout  = empty ? din : mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        mem_d = mem_q;
        if (store) begin
            mem_d[wr_ptr_q] = din;
        end
        wr_ptr_d = wr_ptr_q ^ store;
        rd_ptr_d = rd_ptr_q ^ drain;
        count_d  = count_q + {1'b0, store} - {1'b0, drain};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Address sequencer for a 1-cycle-latency synchronous ROM feeding a
// valid/ready stream; reads are credit-limited so the 2-entry FIFO never overflows.
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int ROM_WIDTH     = 8,
    parameter int ROM_ADDR_BITS = 10,
    parameter int LEN_BITS      = ROM_ADDR_BITS + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROM_ADDR_BITS-1:0] base_addr,
    input  logic [LEN_BITS-1:0]      length,
    output logic                     busy,
    output logic                     done,
    output logic [ROM_ADDR_BITS-1:0] rom_addr,
    output logic                     rom_en,
    input  logic [ROM_WIDTH-1:0]     rom_data,
    output logic [ROM_WIDTH-1:0]     m_data,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready
);

    state_e                   state_q, state_d;
    logic [ROM_ADDR_BITS-1:0] base_q, base_d;
    logic [LEN_BITS-1:0]      len_q, len_d;
    logic [LEN_BITS-1:0]      issue_cnt_q, issue_cnt_d;
    logic                     inflight_q, inflight_d;
    logic                     inflight_last_q, inflight_last_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [ROM_WIDTH:0]       fifo_dout;
    logic [1:0]               fifo_count;
    logic                     pop;
    logic                     issue_last;
    logic signed [3:0]        credit;

    rom_stream_fifo #(
        .WIDTH (ROM_WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   ({inflight_last_q, rom_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign m_valid = (fifo_count != 2'd0) | inflight_q;
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? fifo_dout[ROM_WIDTH-1:0] : '0;
    assign m_last  = m_valid & fifo_dout[ROM_WIDTH];

    // Slots left once stored words and the read in flight are counted; a pop frees one now.
    assign credit = 4'sd2 - $signed({2'b00, fifo_count}) - $signed({3'b000, inflight_q})
                    + $signed({3'b000, pop});
    assign rom_en     = (state_q == ST_ISSUE) && (credit > 4'sd0);
    assign rom_addr   = base_q + issue_cnt_q[ROM_ADDR_BITS-1:0];
    assign issue_last = (issue_cnt_q == len_q - LEN_BITS'(1));
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        len_d           = len_q;
        issue_cnt_d     = issue_cnt_q;
        inflight_d      = rom_en;
        inflight_last_d = rom_en & issue_last;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    len_d       = length;
                    issue_cnt_d = '0;
                    state_d     = (length == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rom_en) begin
                    issue_cnt_d = issue_cnt_q + LEN_BITS'(1);
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && m_last) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            len_q           <= '0;
            issue_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            issue_cnt_q     <= issue_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a behavioural 1-cycle ROM holding
// a known image; a negedge monitor records issued addresses and accepted words.
module tb_rom_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic [9:0]  rom_addr;
    logic        rom_en;
    logic [7:0]  rom_data;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;

    int n_total = 0;
    int n_bad   = 0;

    rom_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_en    (rom_en),
        .rom_data  (rom_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_img(input int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    logic [7:0] rom_q = 8'h00;
    always @(posedge clk) begin
        if (rom_en) rom_q <= rom_img(int'(rom_addr));
    end
    assign rom_data = rom_q;

    // Monitor state
    logic       mon_clr = 1'b0;
    int         cyc = 0;
    int         en_cnt, valid_cnt, done_cnt, done_cyc;
    int         first_en_cyc, first_hs_cyc, last_hs_cyc;
    int         credit_viol, stab_viol, outstanding;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] rx_q[$];
    logic [9:0] addr_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            en_cnt       <= 0;
            valid_cnt    <= 0;
            done_cnt     <= 0;
            done_cyc     <= -1;
            first_en_cyc <= -1;
            first_hs_cyc <= -1;
            last_hs_cyc  <= -1;
            credit_viol  <= 0;
            stab_viol    <= 0;
            rx_q.delete();
            addr_q.delete();
        end
        if (rst) begin
            outstanding <= 0;
            prev_stall  <= 1'b0;
        end else if (!mon_clr) begin
            if (rom_en) begin
                if (en_cnt == 0) first_en_cyc <= cyc;
                en_cnt <= en_cnt + 1;
                addr_q.push_back(rom_addr);
                if (outstanding - int'(m_valid & m_ready) > 1) credit_viol <= credit_viol + 1;
            end
            if (m_valid) valid_cnt <= valid_cnt + 1;
            if (m_valid && m_ready) begin
                if (rx_q.size() == 0) first_hs_cyc <= cyc;
                last_hs_cyc <= cyc;
                rx_q.push_back({m_last, m_data});
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (prev_stall && !(m_valid && m_data == prev_data && m_last == prev_last))
                stab_viol <= stab_viol + 1;
            prev_stall  <= m_valid & ~m_ready;
            prev_data   <= m_data;
            prev_last   <= m_last;
            outstanding <= outstanding + int'(rom_en) - int'(m_valid & m_ready);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return k >= 6;
        endcase
    endfunction

    // Launches a transfer and runs until done is seen or the budget runs out.
    // ign_k > 0 pulses a competing start on that cycle of the transfer.
    task automatic run_xfer(input string tag, input logic [9:0] base, input logic [10:0] len,
                            input int mode, input int ign_k, input int budget, output int s_cyc);
        int k;
        mon_clr   = 1'b1;
        base_addr = base;
        length    = len;
        start     = 1'b1;
        s_cyc     = cyc;
        m_ready   = rdy(mode, 0);
        tick();
        mon_clr = 1'b0;
        start   = 1'b0;
        k = 1;
        while (done_cnt == 0 && k <= budget) begin
            m_ready = rdy(mode, k);
            if (k == ign_k) begin
                start     = 1'b1;
                base_addr = 10'h100;
                length    = 11'd2;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        chk({tag, "_timeout"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) tick();
    endtask

    task automatic check_words(input string tag, input logic [9:0] base, input int len);
        int errs = 0;
        logic [8:0] exp;
        chk({tag, "_cnt"}, rx_q.size(), len);
        for (int j = 0; j < rx_q.size() && j < len; j++) begin
            exp = {j == len - 1, rom_img((int'(base) + j) % 1024)};
            if (len <= 16) chk($sformatf("%s_w%0d", tag, j), 32'(rx_q[j]), 32'(exp));
            else if (rx_q[j] !== exp) errs++;
        end
        if (len > 16) chk({tag, "_errs"}, errs, 0);
    endtask

    initial begin
        int s;
        int k;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b0;
        repeat (3) tick();
        chk("rst_busy",  32'(busy),     0);
        chk("rst_done",  32'(done),     0);
        chk("rst_en",    32'(rom_en),   0);
        chk("rst_valid", 32'(m_valid),  0);
        chk("rst_last",  32'(m_last),   0);
        chk("rst_data",  32'(m_data),   0);
        chk("rst_addr",  32'(rom_addr), 0);
        rst = 1'b0;
        tick();

        // Continuous flow
        run_xfer("cont", 10'h010, 11'd8, 0, 0, 100, s);
        check_words("cont", 10'h010, 8);
        chk("cont_first_en",    first_en_cyc, s + 1);
        chk("cont_first_valid", first_hs_cyc, s + 2);
        chk("cont_rate",        last_hs_cyc - first_hs_cyc, 7);
        chk("cont_done_cyc",    done_cyc, last_hs_cyc + 1);
        chk("cont_done_cnt",    done_cnt, 1);
        chk("cont_credit",      credit_viol, 0);
        chk("cont_busy_after",  32'(busy), 0);

        // Backpressure
        run_xfer("bp", 10'h000, 11'd5, 1, 0, 200, s);
        check_words("bp", 10'h000, 5);
        chk("bp_credit",   credit_viol, 0);
        chk("bp_stable",   stab_viol, 0);
        chk("bp_done_cnt", done_cnt, 1);
        chk("bp_done_cyc", done_cyc, last_hs_cyc + 1);

        // Wrap-around
        run_xfer("wrap", 10'h3FE, 11'd4, 0, 0, 100, s);
        chk("wrap_addr_cnt", addr_q.size(), 4);
        for (int j = 0; j < addr_q.size() && j < 4; j++)
            chk($sformatf("wrap_addr%0d", j), 32'(addr_q[j]), (32'h3FE + j) % 32'd1024);
        check_words("wrap", 10'h3FE, 4);

        // Zero length
        run_xfer("zero", 10'h123, 11'd0, 0, 0, 20, s);
        chk("zero_en",       en_cnt, 0);
        chk("zero_valid",    valid_cnt, 0);
        chk("zero_done_cyc", done_cyc, s + 1);
        chk("zero_done_cnt", done_cnt, 1);

        // Start during DRAIN is ignored
        run_xfer("ign", 10'h040, 11'd2, 3, 4, 100, s);
        check_words("ign", 10'h040, 2);
        chk("ign_en_cnt",   en_cnt, 2);
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_busy",     32'(busy), 0);

        // Reset mid-transfer
        mon_clr   = 1'b1;
        base_addr = 10'h080;
        length    = 11'd10;
        start     = 1'b1;
        m_ready   = 1'b1;
        tick();
        mon_clr = 1'b0;
        start   = 1'b0;
        k = 0;
        while (rx_q.size() < 3 && k < 50) begin
            tick();
            k++;
        end
        chk("mid_pre_words", rx_q.size(), 3);
        rst = 1'b1;
        #1;
        chk("mid_valid", 32'(m_valid), 0);
        chk("mid_busy",  32'(busy),    0);
        chk("mid_en",    32'(rom_en),  0);
        chk("mid_done",  32'(done),    0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("mid_post_words", rx_q.size(), 3);
        chk("mid_post_done",  done_cnt, 0);
        run_xfer("after", 10'h020, 11'd2, 0, 0, 100, s);
        check_words("after", 10'h020, 2);

        // Full ROM with random backpressure
        run_xfer("full", 10'h155, 11'd1024, 2, 0, 6000, s);
        check_words("full", 10'h155, 1024);
        chk("full_en_cnt",   en_cnt, 1024);
        chk("full_credit",   credit_viol, 0);
        chk("full_stable",   stab_viol, 0);
        chk("full_done_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
